// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared encodings and helpers for the fetch/data memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_IF   = 2'b01;
    localparam logic [1:0] OWNER_DM   = 2'b10;

    localparam logic PRI_DM_FIRST = 1'b0;
    localparam logic PRI_IF_FIRST = 1'b1;

    // Counter width: enough bits to hold the limit, never narrower than 4.
    function automatic int starve_cnt_width(input int limit);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << w) <= limit) w = w + 1;
        end
        return (w < 4) ? 4 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_starve_counter.sv
`default_nettype none
// ============================================================================
// Module   : arb_starve_counter
// Brief    : Counts consecutive denied fetch cycles, saturating at the limit.
// Revision : 1.0 - initial release
// ============================================================================
module arb_starve_counter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CW           = starve_cnt_width(STARVE_LIMIT)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_wait,
    input  logic          i_clear,
    output logic [CW-1:0] o_cnt,
    output logic          o_boost
);

    localparam logic [CW-1:0] c_limit = CW'(STARVE_LIMIT);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_clear || !i_wait) begin
            r_cnt <= '0;
        end else if (r_cnt != c_limit) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt   = r_cnt;
    assign o_boost = (r_cnt == c_limit);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Shares a single-port synchronous memory between instruction fetch
//            and data access, data-first with a starvation escape for fetch.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW           = 8,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_if_req,
    input  logic [AW-1:0] i_if_addr,
    output logic          o_if_gnt,
    output logic          o_if_rvalid,
    output logic [DW-1:0] o_if_rdata,
    input  logic          i_dm_req,
    input  logic          i_dm_we,
    input  logic [AW-1:0] i_dm_addr,
    input  logic [DW-1:0] i_dm_wdata,
    output logic          o_dm_gnt,
    output logic          o_dm_rvalid,
    output logic [DW-1:0] o_dm_rdata,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    output logic          o_mem_read,
    output logic          o_mem_write,
    input  logic [DW-1:0] i_mem_rdata,
    output logic          o_stall_if
);

    localparam int CW = starve_cnt_width(STARVE_LIMIT);

    logic          w_if_gnt;
    logic          w_dm_gnt;
    logic          w_boost;
    logic          w_pri;
    logic [CW-1:0] w_unused_starve_cnt;
    logic [1:0]    r_rsp_owner;

    arb_starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CW           (CW)
    ) u_starve (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_wait  (i_if_req),
        .i_clear (w_if_gnt),
        .o_cnt   (w_unused_starve_cnt),
        .o_boost (w_boost)
    );

    assign w_pri = w_boost ? PRI_IF_FIRST : PRI_DM_FIRST;

    // Grants are held low throughout reset so the memory sees no access.
    always_comb begin
        w_if_gnt = 1'b0;
        w_dm_gnt = 1'b0;
        if (!i_reset) begin
            if (w_pri == PRI_IF_FIRST) begin
                w_if_gnt = i_if_req;
                w_dm_gnt = i_dm_req & ~i_if_req;
            end else begin
                w_dm_gnt = i_dm_req;
                w_if_gnt = i_if_req & ~i_dm_req;
            end
        end
    end

    always_comb begin
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_read  = 1'b0;
        o_mem_write = 1'b0;
        if (w_if_gnt) begin
            o_mem_addr = i_if_addr;
            o_mem_read = 1'b1;
        end else if (w_dm_gnt) begin
            o_mem_addr  = i_dm_addr;
            o_mem_wdata = i_dm_wdata;
            o_mem_read  = ~i_dm_we;
            o_mem_write = i_dm_we;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rsp_owner <= OWNER_NONE;
        end else if (w_if_gnt) begin
            r_rsp_owner <= OWNER_IF;
        end else if (w_dm_gnt && !i_dm_we) begin
            r_rsp_owner <= OWNER_DM;
        end else begin
            r_rsp_owner <= OWNER_NONE;
        end
    end

    assign o_if_gnt    = w_if_gnt;
    assign o_dm_gnt    = w_dm_gnt;
    assign o_stall_if  = i_if_req & ~w_if_gnt;
    assign o_if_rvalid = (r_rsp_owner == OWNER_IF);
    assign o_dm_rvalid = (r_rsp_owner == OWNER_DM);
    assign o_if_rdata  = i_mem_rdata;
    assign o_dm_rdata  = i_mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed self-checking bench for mem_arbiter with a memory model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          dm_req, dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt, dm_rvalid;
    logic [DW-1:0] dm_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_read, mem_write;
    logic [DW-1:0] mem_rdata;
    logic          stall_if;

    int chk  = 0;
    int pass = 0;

    logic [DW-1:0] mem [0:255];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
        else if (mem_read) mem_rdata <= mem[mem_addr];
    end

    mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_if_req(if_req), .i_if_addr(if_addr),
        .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
        .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
        .o_dm_gnt(dm_gnt), .o_dm_rvalid(dm_rvalid), .o_dm_rdata(dm_rdata),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .o_mem_read(mem_read), .o_mem_write(mem_write),
        .i_mem_rdata(mem_rdata), .o_stall_if(stall_if)
    );

    // Inputs change just after the rising edge; outputs are sampled at the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ir, input logic [AW-1:0] ia,
                         input logic dr, input logic dw,
                         input logic [AW-1:0] da, input logic [DW-1:0] dd);
        if_req = ir; if_addr = ia; dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = dd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 8'h04, 1'b1, 1'b0, 8'h10, 32'h0);
        next_cycle(); next_cycle();
        @(negedge clk);
        chk++; if (if_gnt !== 1'b0 || dm_gnt !== 1'b0) $display("FAIL reset_gnt: got if=%b dm=%b want 0 0", if_gnt, dm_gnt); else pass++;
        chk++; if (mem_read !== 1'b0 || mem_write !== 1'b0) $display("FAIL reset_mem_en: got rd=%b wr=%b want 0 0", mem_read, mem_write); else pass++;
        chk++; if (if_rvalid !== 1'b0 || dm_rvalid !== 1'b0) $display("FAIL reset_rvalid: got if=%b dm=%b want 0 0", if_rvalid, dm_rvalid); else pass++;
        next_cycle();
        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        chk++; if (if_rvalid !== 1'b0 || dm_rvalid !== 1'b0) $display("FAIL post_reset_rvalid: got if=%b dm=%b want 0 0", if_rvalid, dm_rvalid); else pass++;
    endtask

    task automatic test_preload();
        logic [AW-1:0] a [4];
        logic [DW-1:0] d [4];
        a[0] = 8'h04; d[0] = 32'h00000013;
        a[1] = 8'h08; d[1] = 32'h11111111;
        a[2] = 8'h10; d[2] = 32'hDEADBEEF;
        a[3] = 8'h0C; d[3] = 32'h22222222;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            drive(1'b0, 8'h00, 1'b1, 1'b1, a[i], d[i]);
            @(negedge clk);
            chk++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== a[i] || mem_wdata !== d[i])
                $display("FAIL preload_write%0d: got wr=%b rd=%b addr=%h wdata=%h want 1 0 %h %h", i, mem_write, mem_read, mem_addr, mem_wdata, a[i], d[i]);
            else pass++;
        end
        next_cycle();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        chk++; if (dm_rvalid !== 1'b0) $display("FAIL write_no_rvalid: got %b want 0", dm_rvalid); else pass++;
    endtask

    task automatic test_fetch_only();
        next_cycle();
        drive(1'b1, 8'h04, 1'b0, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        chk++; if (if_gnt !== 1'b1 || dm_gnt !== 1'b0) $display("FAIL fetch_gnt: got if=%b dm=%b want 1 0", if_gnt, dm_gnt); else pass++;
        chk++; if (stall_if !== 1'b0) $display("FAIL fetch_stall: got %b want 0", stall_if); else pass++;
        chk++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 8'h04) $display("FAIL fetch_mem: got rd=%b wr=%b addr=%h want 1 0 04", mem_read, mem_write, mem_addr); else pass++;
        next_cycle();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        chk++; if (if_rvalid !== 1'b1 || dm_rvalid !== 1'b0) $display("FAIL fetch_rvalid: got if=%b dm=%b want 1 0", if_rvalid, dm_rvalid); else pass++;
        chk++; if (if_rdata !== 32'h00000013) $display("FAIL fetch_rdata: got %h want 00000013", if_rdata); else pass++;
    endtask

    task automatic test_simultaneous();
        next_cycle();
        drive(1'b1, 8'h08, 1'b1, 1'b0, 8'h10, 32'h0);
        @(negedge clk);
        chk++; if (dm_gnt !== 1'b1 || if_gnt !== 1'b0) $display("FAIL simul_c0_gnt: got if=%b dm=%b want 0 1", if_gnt, dm_gnt); else pass++;
        chk++; if (stall_if !== 1'b1) $display("FAIL simul_c0_stall: got %b want 1", stall_if); else pass++;
        chk++; if (mem_addr !== 8'h10 || mem_read !== 1'b1) $display("FAIL simul_c0_mem: got addr=%h rd=%b want 10 1", mem_addr, mem_read); else pass++;
        next_cycle();
        drive(1'b1, 8'h08, 1'b0, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        chk++; if (dm_rvalid !== 1'b1 || dm_rdata !== 32'hDEADBEEF) $display("FAIL simul_c1_dm_rsp: got v=%b d=%h want 1 deadbeef", dm_rvalid, dm_rdata); else pass++;
        chk++; if (if_gnt !== 1'b1 || stall_if !== 1'b0) $display("FAIL simul_c1_if_gnt: got gnt=%b stall=%b want 1 0", if_gnt, stall_if); else pass++;
        next_cycle();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        chk++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h11111111 || dm_rvalid !== 1'b0)
            $display("FAIL simul_c2_if_rsp: got v=%b d=%h dmv=%b want 1 11111111 0", if_rvalid, if_rdata, dm_rvalid);
        else pass++;
    endtask

    task automatic test_starvation();
        logic exp_if;
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            drive(1'b1, 8'h04, 1'b1, 1'b0, 8'h10, 32'h0);
            exp_if = ((c % 5) == 4);
            @(negedge clk);
            chk++; if (if_gnt !== exp_if || dm_gnt !== !exp_if)
                $display("FAIL starve_c%0d_gnt: got if=%b dm=%b want %b %b", c, if_gnt, dm_gnt, exp_if, !exp_if);
            else pass++;
            if (c > 0) begin
                chk++; if (if_rvalid !== ((c % 5) == 0) || dm_rvalid !== ((c % 5) != 0))
                    $display("FAIL starve_c%0d_rvalid: got if=%b dm=%b want %b %b", c, if_rvalid, dm_rvalid, ((c % 5) == 0), ((c % 5) != 0));
                else pass++;
            end
        end
        next_cycle();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        chk++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h00000013) $display("FAIL starve_last_rsp: got v=%b d=%h want 1 00000013", if_rvalid, if_rdata); else pass++;
    endtask

    task automatic test_back_to_back();
        next_cycle();
        drive(1'b0, 8'h00, 1'b1, 1'b1, 8'h20, 32'hCAFEF00D);
        @(negedge clk);
        chk++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || dm_gnt !== 1'b1) $display("FAIL wr_c0: got wr=%b rd=%b gnt=%b want 1 0 1", mem_write, mem_read, dm_gnt); else pass++;
        next_cycle();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h20, 32'h0);
        @(negedge clk);
        chk++; if (dm_rvalid !== 1'b0 || if_rvalid !== 1'b0) $display("FAIL wr_c1_rvalid: got dm=%b if=%b want 0 0", dm_rvalid, if_rvalid); else pass++;
        chk++; if (mem_write !== 1'b0 || mem_read !== 1'b1) $display("FAIL wr_c1_mem: got wr=%b rd=%b want 0 1", mem_write, mem_read); else pass++;
        next_cycle();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        chk++; if (dm_rvalid !== 1'b1 || dm_rdata !== 32'hCAFEF00D) $display("FAIL wr_c2_rsp: got v=%b d=%h want 1 cafef00d", dm_rvalid, dm_rdata); else pass++;
        chk++; if (mem_write !== 1'b0) $display("FAIL wr_c2_mem_write: got %b want 0", mem_write); else pass++;
    endtask

    task automatic test_reset_mid();
        // Fetch granted, then reset: the pending response must be dropped.
        next_cycle();
        drive(1'b1, 8'h04, 1'b0, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        chk++; if (if_gnt !== 1'b1) $display("FAIL rstmid_if_gnt: got %b want 1", if_gnt); else pass++;
        next_cycle();
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk++; if (if_rvalid !== 1'b0 || dm_rvalid !== 1'b0) $display("FAIL rstmid_rvalid: got if=%b dm=%b want 0 0", if_rvalid, dm_rvalid); else pass++;
        // Build up starvation to 3, reset, then DM must win four more times.
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            drive(1'b1, 8'h04, 1'b1, 1'b0, 8'h10, 32'h0);
        end
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk++; if (if_gnt !== 1'b0 || dm_gnt !== 1'b0 || mem_read !== 1'b0) $display("FAIL rstmid_forced: got if=%b dm=%b rd=%b want 0 0 0", if_gnt, dm_gnt, mem_read); else pass++;
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            rst = 1'b0;
            @(negedge clk);
            if (c == 0) begin
                chk++; if (dm_rvalid !== 1'b0 || if_rvalid !== 1'b0) $display("FAIL rstmid2_rvalid: got if=%b dm=%b want 0 0", if_rvalid, dm_rvalid); else pass++;
            end
            chk++; if (dm_gnt !== (c != 4) || if_gnt !== (c == 4))
                $display("FAIL rstmid2_c%0d_gnt: got if=%b dm=%b want %b %b", c, if_gnt, dm_gnt, (c == 4), (c != 4));
            else pass++;
        end
        next_cycle();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
    endtask

    task automatic test_idle();
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            drive(1'b0, 8'h5A, 1'b0, 1'b1, 8'hA5, 32'h12345678);
            @(negedge clk);
            chk++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_addr !== 8'h00 || mem_wdata !== 32'h0)
                $display("FAIL idle_c%0d_mem: got rd=%b wr=%b addr=%h wd=%h want 0 0 00 0", c, mem_read, mem_write, mem_addr, mem_wdata);
            else pass++;
            if (c > 0) begin
                chk++; if (if_rvalid !== 1'b0 || dm_rvalid !== 1'b0 || stall_if !== 1'b0)
                    $display("FAIL idle_c%0d_out: got ifv=%b dmv=%b stall=%b want 0 0 0", c, if_rvalid, dm_rvalid, stall_if);
                else pass++;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
        test_reset();
        test_preload();
        test_fetch_only();
        test_simultaneous();
        test_starvation();
        test_back_to_back();
        test_reset_mid();
        test_idle();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
`default_nettype wire
